// File: rtl/led_driver_rx.sv
// LED-driver serial bus receiver: samples sdi/dclk/le/gclk and the row lines,
// deserialises 16-bit words MSB-first, classifies le pulses into driver
// commands by their dclk count, and measures gclk rises per scan row.
module led_driver_rx #(
  parameter int BOARDS = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sdi,
  input  logic        dclk,
  input  logic        le,
  input  logic        gclk,
  input  logic        a,
  input  logic        b,
  input  logic        c,
  input  logic        d,
  output logic        word_valid,
  output logic [15:0] word_data,
  output logic [7:0]  word_index,
  output logic        cmd_valid,
  output logic [2:0]  cmd_code,
  output logic [15:0] cmd_word,
  output logic [4:0]  cmd_le_count,
  output logic [15:0] cmd_bits,
  output logic        row_valid,
  output logic [3:0]  row_id,
  output logic [7:0]  row_gclks
);

  localparam logic [7:0] WORD_LAST = 8'(BOARDS * 16 - 1);

  // Command classification by the number of dclk rises seen while le was high.
  function automatic logic [2:0] cmd_code_of(input logic [4:0] le_count);
    logic [2:0] code;
    case (le_count)
      5'd1:    code = 3'd0;
      5'd3:    code = 3'd1;
      5'd4:    code = 3'd2;
      5'd6:    code = 3'd3;
      5'd12:   code = 3'd4;
      5'd14:   code = 3'd5;
      default: code = 3'd7;
    endcase
    return code;
  endfunction

  logic       sdi_s1_r, dclk_s1_r, le_s1_r, gclk_s1_r;
  logic       dclk_s2_r, le_s2_r, gclk_s2_r;
  logic [3:0] row_s1_r, row_s2_r;

  logic [15:0] shreg_r;
  logic [3:0]  bit_mod_r;
  logic [15:0] bits_cnt_r;
  logic [4:0]  le_cnt_r;
  logic [7:0]  word_cnt_r;
  logic [7:0]  gclk_cnt_r;

  logic        dclk_rise_s, le_fall_s, gclk_rise_s, row_change_s;
  logic [15:0] shreg_shift_s;
  logic [15:0] bits_inc_s;
  logic [4:0]  le_inc_s;
  logic [7:0]  word_inc_s;
  logic [7:0]  gclk_inc_s;

  // Two-stage input sampling; s2 is the previous s1 for edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sdi_s1_r  <= 1'b0;
      dclk_s1_r <= 1'b0;
      le_s1_r   <= 1'b0;
      gclk_s1_r <= 1'b0;
      row_s1_r  <= 4'd0;
      dclk_s2_r <= 1'b0;
      le_s2_r   <= 1'b0;
      gclk_s2_r <= 1'b0;
      row_s2_r  <= 4'd0;
    end else begin
      sdi_s1_r  <= sdi;
      dclk_s1_r <= dclk;
      le_s1_r   <= le;
      gclk_s1_r <= gclk;
      row_s1_r  <= {a, b, c, d};
      dclk_s2_r <= dclk_s1_r;
      le_s2_r   <= le_s1_r;
      gclk_s2_r <= gclk_s1_r;
      row_s2_r  <= row_s1_r;
    end
  end

  // Edge strobes and saturating/wrapping next-count values.
  always_comb begin
    dclk_rise_s   = dclk_s1_r & ~dclk_s2_r;
    le_fall_s     = ~le_s1_r & le_s2_r;
    gclk_rise_s   = gclk_s1_r & ~gclk_s2_r;
    row_change_s  = (row_s1_r != row_s2_r);
    shreg_shift_s = {shreg_r[14:0], sdi_s1_r};
    bits_inc_s    = (bits_cnt_r == 16'hFFFF) ? bits_cnt_r : bits_cnt_r + 16'd1;
    le_inc_s      = (le_cnt_r == 5'd31) ? le_cnt_r : le_cnt_r + 5'd1;
    word_inc_s    = (word_cnt_r == WORD_LAST) ? 8'd0 : word_cnt_r + 8'd1;
    gclk_inc_s    = (gclk_cnt_r == 8'hFF) ? gclk_cnt_r : gclk_cnt_r + 8'd1;
  end

  // Deserialiser and command decoder; a command event takes priority over a
  // coincident dclk rise, which then becomes the first bit of the next frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg_r      <= 16'd0;
      bit_mod_r    <= 4'd0;
      bits_cnt_r   <= 16'd0;
      le_cnt_r     <= 5'd0;
      word_cnt_r   <= 8'd0;
      word_valid   <= 1'b0;
      word_data    <= 16'd0;
      word_index   <= 8'd0;
      cmd_valid    <= 1'b0;
      cmd_code     <= 3'd0;
      cmd_word     <= 16'd0;
      cmd_le_count <= 5'd0;
      cmd_bits     <= 16'd0;
    end else begin
      word_valid <= 1'b0;
      cmd_valid  <= 1'b0;
      if (le_fall_s) begin
        cmd_valid    <= 1'b1;
        cmd_code     <= cmd_code_of(le_cnt_r);
        cmd_le_count <= le_cnt_r;
        cmd_bits     <= bits_cnt_r;
        cmd_word     <= shreg_r;
        le_cnt_r     <= 5'd0;
        word_cnt_r   <= 8'd0;
        if (dclk_rise_s) begin
          shreg_r    <= shreg_shift_s;
          bits_cnt_r <= 16'd1;
          bit_mod_r  <= 4'd1;
        end else begin
          bits_cnt_r <= 16'd0;
          bit_mod_r  <= 4'd0;
        end
      end else if (dclk_rise_s) begin
        shreg_r    <= shreg_shift_s;
        bit_mod_r  <= bit_mod_r + 4'd1;
        bits_cnt_r <= bits_inc_s;
        if (le_s1_r) begin
          le_cnt_r <= le_inc_s;
        end
        if (bit_mod_r == 4'd15) begin
          word_valid <= 1'b1;
          word_data  <= shreg_shift_s;
          word_index <= word_cnt_r;
          word_cnt_r <= word_inc_s;
        end
      end
    end
  end

  // Per-row gclk measurement, reported when the row address changes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gclk_cnt_r <= 8'd0;
      row_valid  <= 1'b0;
      row_id     <= 4'd0;
      row_gclks  <= 8'd0;
    end else begin
      row_valid <= 1'b0;
      if (row_change_s) begin
        row_valid  <= 1'b1;
        row_id     <= row_s2_r;
        row_gclks  <= gclk_cnt_r;
        gclk_cnt_r <= gclk_rise_s ? 8'd1 : 8'd0;
      end else if (gclk_rise_s) begin
        gclk_cnt_r <= gclk_inc_s;
      end
    end
  end

endmodule

// File: tb/tb_led_driver_rx.sv
// Bench for led_driver_rx: transaction-level drivers feed a reference model
// that queues expected words, commands and row reports; a monitor pops and
// compares whenever the receiver pulses a valid.
module tb_led_driver_rx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sdi = 1'b0, dclk = 1'b0, le = 1'b0, gclk = 1'b0;
  logic [3:0]  row_drv = 4'd0;
  logic        word_valid, cmd_valid, row_valid;
  logic [15:0] word_data, cmd_word, cmd_bits;
  logic [7:0]  word_index, row_gclks;
  logic [2:0]  cmd_code;
  logic [4:0]  cmd_le_count;
  logic [3:0]  row_id;

  int tests = 0;
  int fails = 0;
  logic mon_en = 1'b0;

  logic [23:0] word_q[$];   // {data, index}
  logic [39:0] cmd_q[$];    // {code, le_count, bits, word}
  logic [11:0] row_q[$];    // {row_id, gclks}

  // reference model state
  logic [15:0] m_hist = 16'd0;
  int          m_bits = 0, m_le = 0, m_words = 0, m_gcnt = 0;
  logic        m_le_lvl = 1'b0;
  logic [3:0]  m_row = 4'd0;

  always #5 clk = ~clk;

  led_driver_rx #(.BOARDS(3)) dut (
    .clk(clk), .rst(rst), .sdi(sdi), .dclk(dclk), .le(le), .gclk(gclk),
    .a(row_drv[3]), .b(row_drv[2]), .c(row_drv[1]), .d(row_drv[0]),
    .word_valid(word_valid), .word_data(word_data), .word_index(word_index),
    .cmd_valid(cmd_valid), .cmd_code(cmd_code), .cmd_word(cmd_word),
    .cmd_le_count(cmd_le_count), .cmd_bits(cmd_bits),
    .row_valid(row_valid), .row_id(row_id), .row_gclks(row_gclks)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [2:0] code_of(input int n);
    case (n)
      1:       return 3'd0;
      3:       return 3'd1;
      4:       return 3'd2;
      6:       return 3'd3;
      12:      return 3'd4;
      14:      return 3'd5;
      default: return 3'd7;
    endcase
  endfunction

  task automatic model_event();
    int le_sat, bits_sat;
    le_sat   = (m_le > 31) ? 31 : m_le;
    bits_sat = (m_bits > 65535) ? 65535 : m_bits;
    cmd_q.push_back({code_of(le_sat), 5'(le_sat), 16'(bits_sat), m_hist});
    m_bits = 0; m_le = 0; m_words = 0;
  endtask

  task automatic model_rise(input logic bit_v, input logic le_v);
    m_hist = {m_hist[14:0], bit_v};
    m_bits++;
    if (le_v) m_le++;
    if (m_bits % 16 == 0) begin
      word_q.push_back({m_hist, 8'(m_words % 48)});
      m_words++;
    end
  endtask

  // one dclk period (1 clk high, 1 clk low); le changes with the rising edge
  task automatic dclk_pulse(input logic bit_v, input logic le_v);
    @(negedge clk);
    if (m_le_lvl && !le_v) model_event();
    sdi = bit_v; le = le_v; dclk = 1'b1;
    model_rise(bit_v, le_v);
    m_le_lvl = le_v;
    @(negedge clk);
    dclk = 1'b0;
  endtask

  task automatic le_set(input logic le_v);
    @(negedge clk);
    if (m_le_lvl && !le_v) model_event();
    le = le_v; m_le_lvl = le_v;
    @(negedge clk);
  endtask

  task automatic gclk_pulse();
    @(negedge clk);
    gclk = 1'b1; m_gcnt++;
    @(negedge clk);
    gclk = 1'b0;
  endtask

  task automatic change_row(input logic [3:0] r, input logic with_rise);
    if (r != m_row) begin
      @(negedge clk);
      row_drv = r;
      if (with_rise) gclk = 1'b1;
      row_q.push_back({m_row, 8'((m_gcnt > 255) ? 255 : m_gcnt)});
      m_gcnt = with_rise ? 1 : 0;
      m_row = r;
      if (with_rise) begin
        @(negedge clk);
        gclk = 1'b0;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("rst_word_valid", 32'(word_valid), 32'd0);
    chk("rst_word_data", 32'(word_data), 32'd0);
    chk("rst_word_index", 32'(word_index), 32'd0);
    chk("rst_cmd_valid", 32'(cmd_valid), 32'd0);
    chk("rst_cmd_code", 32'(cmd_code), 32'd0);
    chk("rst_cmd_word", 32'(cmd_word), 32'd0);
    chk("rst_cmd_le_count", 32'(cmd_le_count), 32'd0);
    chk("rst_cmd_bits", 32'(cmd_bits), 32'd0);
    chk("rst_row_valid", 32'(row_valid), 32'd0);
    chk("rst_row_id", 32'(row_id), 32'd0);
    chk("rst_row_gclks", 32'(row_gclks), 32'd0);
    sdi = 1'b0; dclk = 1'b0; le = 1'b0; gclk = 1'b0; row_drv = 4'd0;
    m_hist = 16'd0; m_bits = 0; m_le = 0; m_words = 0; m_gcnt = 0;
    m_le_lvl = 1'b0; m_row = 4'd0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    mon_en = 1'b1;
  endtask

  // monitor: every valid pulse must match the oldest expected entry
  always @(negedge clk) begin
    logic [23:0] we;
    logic [39:0] ce;
    logic [11:0] re;
    if (mon_en && rst) begin
      if (word_valid) begin
        if (word_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL word_unexpected: got data %0h index %0d, expected none", word_data, word_index);
        end else begin
          we = word_q.pop_front();
          chk("word_data", 32'(word_data), 32'(we[23:8]));
          chk("word_index", 32'(word_index), 32'(we[7:0]));
        end
      end
      if (cmd_valid) begin
        if (cmd_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL cmd_unexpected: got code %0d le %0d bits %0d, expected none", cmd_code, cmd_le_count, cmd_bits);
        end else begin
          ce = cmd_q.pop_front();
          chk("cmd_code", 32'(cmd_code), 32'(ce[39:37]));
          chk("cmd_le_count", 32'(cmd_le_count), 32'(ce[36:32]));
          chk("cmd_bits", 32'(cmd_bits), 32'(ce[31:16]));
          chk("cmd_word", 32'(cmd_word), 32'(ce[15:0]));
        end
      end
      if (row_valid) begin
        if (row_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL row_unexpected: got id %0d gclks %0d, expected none", row_id, row_gclks);
        end else begin
          re = row_q.pop_front();
          chk("row_id", 32'(row_id), 32'(re[11:8]));
          chk("row_gclks", 32'(row_gclks), 32'(re[7:0]));
        end
      end
    end
  end

  initial begin
    logic [15:0] pat;
    logic [15:0] cfg;
    logic        le_next;
    int          r;
    pat = 16'hA5C3;
    cfg = 16'h0370;

    do_reset();

    // data latch: 16 bits, le on the last rise only
    for (int i = 0; i < 16; i++) dclk_pulse(pat[15-i], (i == 15));
    le_set(1'b0);

    // preactivate: le falls with the 16th rise
    dclk_pulse(1'b0, 1'b0);
    repeat (14) dclk_pulse(1'($urandom_range(0, 1)), 1'b1);
    dclk_pulse(1'b1, 1'b0);
    le_set(1'b1);
    le_set(1'b0);

    // config-1 write across three chained boards
    for (int i = 0; i < 48; i++) dclk_pulse(cfg[15-(i%16)], (i >= 44));
    le_set(1'b0);

    // le held for 40 rises, falling with a rise
    repeat (40) dclk_pulse(1'($urandom_range(0, 1)), 1'b1);
    dclk_pulse(1'($urandom_range(0, 1)), 1'b0);
    repeat (5) dclk_pulse(1'($urandom_range(0, 1)), 1'b0);
    dclk_pulse(1'($urandom_range(0, 1)), 1'b1);
    le_set(1'b0);

    // word_index wrap: 50 words without a command
    repeat (800) dclk_pulse(1'($urandom_range(0, 1)), 1'b0);
    dclk_pulse(1'b0, 1'b1);
    le_set(1'b0);

    // row measurement, saturation and coincident gclk rise
    repeat (138) gclk_pulse();
    change_row(4'd1, 1'b0);
    repeat (300) gclk_pulse();
    change_row(4'd2, 1'b1);
    repeat (5) gclk_pulse();
    change_row(4'd9, 1'b0);

    // reset mid-word and mid-le-pulse, then a fresh frame
    repeat (7) dclk_pulse(1'($urandom_range(0, 1)), 1'b0);
    repeat (2) dclk_pulse(1'($urandom_range(0, 1)), 1'b1);
    repeat (3) gclk_pulse();
    do_reset();
    for (int i = 0; i < 16; i++) dclk_pulse(pat[i], (i == 15));
    le_set(1'b0);

    // randomized traffic
    le_next = 1'b0;
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 19);
      if (r < 14) begin
        if ($urandom_range(0, 9) == 0) le_next = ~le_next;
        dclk_pulse(1'($urandom_range(0, 1)), le_next);
      end else if (r < 16) begin
        le_next = ~m_le_lvl;
        le_set(le_next);
      end else if (r < 19) begin
        gclk_pulse();
      end else begin
        change_row(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      end
    end
    le_set(1'b0);

    repeat (10) @(negedge clk);
    chk("word_q_drained", 32'(word_q.size()), 32'd0);
    chk("cmd_q_drained", 32'(cmd_q.size()), 32'd0);
    chk("row_q_drained", 32'(row_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/led_driver_rx.md
# led_driver_rx

Receiver and decoder for the LED-driver serial bus (sdi/dclk/le/gclk plus row lines a-d) that the matrix output block drives. It samples the bus with the system clock, deserialises 16-bit words MSB-first, and classifies each le pulse by its dclk count into a driver command. It also measures gclk pulses per scan row. It sits on the bus as an in-system monitor and as the bench-side decoder for the matrix output path.

## Interface
- BOARDS, 3: chained driver chips; word_index wraps at BOARDS*16
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset)
- sdi, dclk, le, gclk  in  1 each  driver bus, synchronous to clk
- a, b, c, d  in  1 each  row address; row = {a,b,c,d}, a = MSB
- word_valid  out  1  one-cycle pulse per 16 received bits
- word_data  out  16  last 16 bits, first-received bit in [15]
- word_index  out  8  words since last command event, 0-based
- cmd_valid  out  1  one-cycle pulse at end of each le pulse
- cmd_code  out  3  0 DATA_LATCH, 1 VSYNC, 2 WR_CFG1, 3 WR_CFG2, 4 EN_OUTPUTS, 5 PREACTIVATE, 7 UNKNOWN
- cmd_word  out  16  shift register content when le fell
- cmd_le_count  out  5  dclk rises seen with le high (saturates 31)
- cmd_bits  out  16  dclk rises since previous command event (saturates 65535)
- row_valid  out  1  one-cycle pulse on row address change
- row_id  out  4  row that just ended
- row_gclks  out  8  gclk rises during that row (saturates 255)

## Operation
- Input stage: sdi, dclk, le, gclk, row each registered once (s1), then again (s2). Edges: dclk_rise = s1 & ~s2, le_fall = ~s1 & s2, gclk_rise = s1 & ~s2, row_change = s1 != s2.
- On dclk_rise: shift sdi_s1 into shreg LSB. Increment bit_mod (4 bits). Increment bits_cnt. If le_s1 = 1, increment le_cnt.
- Word emission: on a dclk_rise that wraps bit_mod 15->0, pulse word_valid. word_data = shreg including the new bit. word_index = word_cnt, then word_cnt increments and wraps to 0 at BOARDS*16.
- Command emission on le_fall: pulse cmd_valid. cmd_le_count = le_cnt, cmd_bits = bits_cnt, cmd_word = shreg.
- Code map for le_cnt: 1 gives DATA_LATCH, 3 VSYNC, 4 WR_CFG1, 6 WR_CFG2, 12 EN_OUTPUTS, 14 PREACTIVATE. Any other value, including 0, gives UNKNOWN.
- After a command event, clear le_cnt, bits_cnt, bit_mod and word_cnt.
- Simultaneous dclk_rise and le_fall:
  - The event is emitted first, using values from before the rise.
  - The concurrent rise then counts as the first bit after the event: bits_cnt = 1, bit_mod = 1, le_cnt = 0, and the bit is shifted in.
- Row measurement: gclk_rise increments gclk_cnt. On row_change, pulse row_valid with row_id = previous row (s2) and row_gclks = gclk_cnt, then set gclk_cnt to 0, or to 1 if gclk_rise occurs in the same cycle.
- Counters saturate; they do not wrap, except bit_mod and word_cnt.

## Timing
- Reset:
  - Every output is 0.
  - shreg, all counters and both input stages are 0.
  - Outputs are asynchronous to reset entry; release is synchronous.
- Latency: an input level captured at clk edge k appears in s1 after k and in s2 after k+1. The resulting output pulse is registered at edge k+1, so it is visible in the cycle after k+1.
- All pulses last exactly 1 cycle. Data outputs hold until the next pulse of the same kind.
- Minimum dclk high or low time is 1 clk. Narrower pulses are undefined.
- Reset asserted mid-word or mid-le-pulse: partial state is discarded and no event is emitted on release.

## Test plan
- 16 dclk rises with sdi pattern 0xA5C3, le high on the 16th rise only -> word_valid with word_data 0xA5C3 and word_index 0; then cmd_valid with code 0, le_count 1, bits 16, cmd_word 0xA5C3.
- Preactivate (1 low, 14 high, 1 low) -> code 5, le_count 14, bits 15; the trailing rise leaves bits_cnt = 1.
- Config-1 write, 48 rises of 0x0370 repeated, le high for the last 4 -> three words 0x0370 with indices 0..2, then code 2, le_count 4, bits 48.
- le held high for 40 rises -> le_count 31, code 7; le_fall coincident with a dclk rise -> event values exclude that rise, next bits_cnt = 1.
- gclk toggling every clk, row changes 0->1 after 138 gclk rises -> row_valid, row_id 0, row_gclks 138. A row held for 300 rises reports 255.
- Assert rst after 9 bits -> all outputs 0 immediately. After release, 16 fresh bits give word_index 0 and bits_cnt counts from 1.
